// File: rtl/csoc_scan_ctrl.sv
// Multi-chain CSoC scan controller: decodes UART command bytes into csoc_clk pulses, reset, SE and TM.
// Optional idle-data timeout in the count/data wait states is enabled by defining SCAN_TIMEOUT_EN.
module csoc_scan_ctrl #(
    parameter int CHAINS      = 4,
    parameter int CLK_DIV     = 4,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_start_o,
    input  logic              tx_ready_i,
    output logic              busy_o,
    output logic              csoc_clk_o,
    output logic              csoc_rstn_o,
    output logic              csoc_test_se_o,
    output logic              csoc_test_tm_o,
    output logic [CHAINS-1:0] csoc_scan_in_o,
    input  logic [CHAINS-1:0] csoc_scan_out_i
);
    // state     | meaning
    // IDLE      | waiting for an opcode
    // CNT_LO/HI | collecting the 16-bit shift count, LSB first
    // SH_DATA   | waiting for the next scan-in byte
    // SH_LOW    | csoc_clk low phase, scan_out sampled on its last cycle
    // SH_HIGH   | csoc_clk high phase
    // SH_TX     | returning the sampled bits, then next bit or ACK
    // CAP_*     | single capture pulse with SE low
    // RST_PULSE | rstn held low across two full csoc_clk pulses
    // ACK       | sending 0xAC
    // REPLY     | sending byte_q (status or NAK)
    typedef enum logic [3:0] {
        S_IDLE, S_CNT_LO, S_CNT_HI, S_SH_DATA, S_SH_LOW, S_SH_HIGH, S_SH_TX,
        S_CAP_LOW, S_CAP_HIGH, S_RST_PULSE, S_ACK, S_REPLY
    } state_t;

    localparam int              DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]      CHAINS_M1 = 4'(CHAINS - 1);
    localparam logic [7:0]      ACK_BYTE  = 8'hAC;
    localparam logic [7:0]      NAK_BYTE  = 8'hEE;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_new;
    logic [7:0]         byte_q, byte_d, tx_q, tx_d, tx_pend, sample_ext;
    logic [1:0]         ph_q, ph_d;
    logic               clk_q, clk_d, rstn_q, rstn_d, se_q, se_d, tm_q, tm_d, ovf_q, ovf_d;
    logic [CHAINS-1:0]  scan_q, scan_d;
    logic               waiting, to_abort;

    assign waiting = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) || (state_q == S_SH_DATA);

`ifdef SCAN_TIMEOUT_EN
    localparam int               TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]  TO_LOAD = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] to_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       to_q <= TO_LOAD;
        else if (!waiting || rx_valid_i) to_q <= TO_LOAD;
        else if (to_q != '0)           to_q <= to_q - TO_W'(1);
    end

    assign to_abort = waiting && !rx_valid_i && (to_q == '0);
`else
    // Without the timeout the wait states never abort; the compare folds to a constant 0.
    assign to_abort = (TIMEOUT_CYC < 0);
`endif

    always_comb begin
        sample_ext = '0;
        sample_ext[CHAINS-1:0] = csoc_scan_out_i;
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q - DIV_W'(1);
        cnt_d      = cnt_q;
        cnt_new    = CNT_W'({rx_data_i, byte_q});
        byte_d     = byte_q;
        ph_d       = ph_q;
        clk_d      = clk_q;
        rstn_d     = rstn_q;
        se_d       = se_q;
        tm_d       = tm_q;
        scan_d     = scan_q;
        ovf_d      = ovf_q;
        tx_pend    = tx_q;
        tx_start_o = 1'b0;

        // Bytes arriving while nothing is listening are dropped and flagged.
        if (rx_valid_i && !waiting && state_q != S_IDLE) ovf_d = 1'b1;

        case (state_q)
            S_IDLE: if (rx_valid_i) begin
                case (rx_data_i)
                    8'h01: begin se_d = 1'b0; rstn_d = 1'b0; ph_d = 2'd0; div_d = DIV_LOAD; state_d = S_RST_PULSE; end
                    8'h02: begin tm_d = 1'b1; state_d = S_ACK; end
                    8'h03: begin tm_d = 1'b0; state_d = S_ACK; end
                    8'h10: begin se_d = 1'b1; state_d = S_CNT_LO; end
                    8'h20: begin se_d = 1'b0; div_d = DIV_LOAD; state_d = S_CAP_LOW; end
                    8'h30: begin byte_d = {ovf_q, tm_q, se_q, rstn_q, CHAINS_M1}; ovf_d = 1'b0; state_d = S_REPLY; end
                    default: begin byte_d = NAK_BYTE; state_d = S_REPLY; end
                endcase
            end
            S_CNT_LO: if (rx_valid_i) begin byte_d = rx_data_i; state_d = S_CNT_HI; end
            S_CNT_HI: if (rx_valid_i) begin
                cnt_d = cnt_new;
                if (cnt_new == '0) begin se_d = 1'b0; state_d = S_ACK; end
                else state_d = S_SH_DATA;
            end
            S_SH_DATA: if (rx_valid_i) begin
                scan_d  = rx_data_i[CHAINS-1:0];
                div_d   = DIV_LOAD;
                state_d = S_SH_LOW;
            end
            S_SH_LOW: if (div_q == '0) begin
                byte_d = sample_ext; clk_d = 1'b1; div_d = DIV_LOAD; state_d = S_SH_HIGH;
            end
            S_SH_HIGH: if (div_q == '0) begin clk_d = 1'b0; state_d = S_SH_TX; end
            S_SH_TX: begin
                tx_pend = byte_q;
                if (tx_ready_i) begin
                    tx_start_o = 1'b1;
                    cnt_d      = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin se_d = 1'b0; state_d = S_ACK; end
                    else state_d = S_SH_DATA;
                end
            end
            S_CAP_LOW: if (div_q == '0) begin clk_d = 1'b1; div_d = DIV_LOAD; state_d = S_CAP_HIGH; end
            S_CAP_HIGH: if (div_q == '0) begin clk_d = 1'b0; state_d = S_ACK; end
            S_RST_PULSE: if (div_q == '0) begin
                div_d = DIV_LOAD;
                ph_d  = ph_q + 2'd1;
                if (ph_q == 2'd3) begin clk_d = 1'b0; rstn_d = 1'b1; state_d = S_ACK; end
                else clk_d = ~clk_q;
            end
            S_ACK: begin
                tx_pend = ACK_BYTE;
                if (tx_ready_i) begin tx_start_o = 1'b1; state_d = S_IDLE; end
            end
            S_REPLY: begin
                tx_pend = byte_q;
                if (tx_ready_i) begin tx_start_o = 1'b1; state_d = S_IDLE; end
            end
            default: state_d = S_IDLE;
        endcase

        if (to_abort) begin se_d = 1'b0; byte_d = NAK_BYTE; state_d = S_REPLY; end

        // tx_data shows the new byte together with tx_start and then holds it.
        tx_d      = tx_start_o ? tx_pend : tx_q;
        tx_data_o = tx_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
            tx_q    <= '0;
            ph_q    <= '0;
            clk_q   <= 1'b0;
            rstn_q  <= 1'b1;
            se_q    <= 1'b0;
            tm_q    <= 1'b0;
            ovf_q   <= 1'b0;
            scan_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            ph_q    <= ph_d;
            clk_q   <= clk_d;
            rstn_q  <= rstn_d;
            se_q    <= se_d;
            tm_q    <= tm_d;
            ovf_q   <= ovf_d;
            scan_q  <= scan_d;
        end
    end

    assign busy_o         = (state_q != S_IDLE);
    assign csoc_clk_o     = clk_q;
    assign csoc_rstn_o    = rstn_q;
    assign csoc_test_se_o = se_q;
    assign csoc_test_tm_o = tm_q;
    assign csoc_scan_in_o = scan_q;

endmodule

// File: tb/tb_csoc_scan_ctrl.sv
// Randomized bench for csoc_scan_ctrl: a FIFO model of the scan chains predicts every returned
// sample, and a status model predicts ovf/tm; the chains themselves are modelled as shift registers.
module tb_csoc_scan_ctrl;
    localparam int CHAINS = 4, CLK_DIV = 3, CNT_W = 16, TIMEOUT_CYC = 200, L = 3;

    logic clk = 1'b0, rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic rx_valid = 1'b0, tx_ready = 1'b1;
    logic [7:0] tx_data;
    logic tx_start, busy, csoc_clk, csoc_rstn, se, tm;
    logic [CHAINS-1:0] scan_in, scan_out;

    int n_cmp = 0, n_bad = 0;
    int pulses = 0, bad_hi = 0, hi_run = 0, rstn_run = 0, last_rstn_low = 0, tm_bad = 0, tx_viol = 0;
    bit ovf_m = 1'b0, tm_m = 1'b0;
    logic [CHAINS-1:0] chain [L];
    logic [CHAINS-1:0] pipe [$];
    logic [7:0] got_q [$];

    always #5 clk = ~clk;

    csoc_scan_ctrl #(.CHAINS(CHAINS), .CLK_DIV(CLK_DIV), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .tx_data_o(tx_data), .tx_start_o(tx_start), .tx_ready_i(tx_ready), .busy_o(busy),
        .csoc_clk_o(csoc_clk), .csoc_rstn_o(csoc_rstn), .csoc_test_se_o(se), .csoc_test_tm_o(tm),
        .csoc_scan_in_o(scan_in), .csoc_scan_out_i(scan_out));

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scan chains: shift on csoc_clk rise only while SE is high.
    initial begin
        for (int i = 0; i < L; i++) chain[i] = CHAINS'($urandom);
        scan_out = chain[L-1];
        for (int i = L - 1; i >= 0; i--) pipe.push_back(chain[i]);
        forever begin
            @(posedge csoc_clk);
            pulses++;
            if (se) begin
                for (int i = L - 1; i > 0; i--) chain[i] = chain[i-1];
                chain[0] = scan_in;
                scan_out = chain[L-1];
            end
        end
    end

    // UART transmitter: records each byte, then stays busy for a random time.
    initial begin
        int busy_c = 0;
        logic s, r;
        logic [7:0] d;
        forever begin
            @(negedge clk);
            s = tx_start; d = tx_data; r = tx_ready;
            @(posedge clk);
            #1;
            if (s === 1'b1) begin
                if (r !== 1'b1) tx_viol++;
                got_q.push_back(d);
                busy_c = $urandom_range(0, 4);
                tx_ready = (busy_c == 0);
            end else if (busy_c > 0) begin
                busy_c--;
                if (busy_c == 0) tx_ready = 1'b1;
            end
        end
    end

    // Phase-width monitor for csoc_clk high and csoc_rstn low.
    initial forever begin
        @(negedge clk);
        if (rst !== 1'b0) begin
            hi_run = 0; rstn_run = 0;
        end else begin
            if (csoc_clk === 1'b1) hi_run++;
            else if (hi_run != 0) begin
                if (hi_run != CLK_DIV) bad_hi++;
                hi_run = 0;
            end
            if (csoc_rstn === 1'b0) begin
                rstn_run++;
                if (tm !== tm_m) tm_bad++;
            end else if (rstn_run != 0) begin
                last_rstn_low = rstn_run; rstn_run = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, output logic ts);
        @(negedge clk);
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        ts = tx_start;
    endtask

    task automatic get_tx(output logic [7:0] b);
        int t = 0;
        while (got_q.size() == 0 && t < 2000) begin @(negedge clk); t++; end
        if (got_q.size() == 0) begin
            chk_eq("tx_timeout_bytes", 32'(got_q.size()), 1);
            b = 8'h00;
        end else b = got_q.pop_front();
    endtask

    task automatic wait_tx_ready();
        int t = 0;
        while (tx_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    endtask

    function automatic logic [7:0] status_exp();
        return {ovf_m, tm_m, 1'b0, 1'b1, 4'(CHAINS - 1)};
    endfunction

    task automatic do_status(input string tag);
        logic [7:0] b; logic ts;
        send_byte(8'h30, ts);
        get_tx(b);
        chk_eq(tag, b, status_exp());
        ovf_m = 1'b0;
    endtask

    task automatic do_simple(input logic [7:0] op, input logic [7:0] exp, input string tag);
        logic [7:0] b; logic ts;
        send_byte(op, ts);
        get_tx(b);
        chk_eq(tag, b, exp);
    endtask

    task automatic do_shift(input logic [7:0] data [$], input bit inject);
        int n = data.size();
        int p0 = pulses;
        logic [7:0] b; logic ts;
        logic [CHAINS-1:0] exp;
        send_byte(8'h10, ts);
        send_byte(8'(n), ts);
        send_byte(8'(n >> 8), ts);
        for (int i = 0; i < n; i++) begin
            send_byte(data[i], ts);
            chk_eq("shift_se_on", se, 1);
            exp = pipe.pop_front();
            pipe.push_back(CHAINS'(data[i]));
            if (inject && i == 0) begin
                int t = 0;
                while (csoc_clk !== 1'b1 && t < 50) begin @(negedge clk); t++; end
                send_byte(8'h55, ts);
                ovf_m = 1'b1;
            end
            get_tx(b);
            chk_eq("shift_sample", b, 32'(exp));
        end
        get_tx(b);
        chk_eq("shift_ack", b, 8'hAC);
        chk_eq("shift_pulses", pulses - p0, n);
        chk_eq("shift_se_off", se, 0);
    endtask

    initial begin
        logic [7:0] b, v;
        logic ts;
        logic [7:0] dq [$];
        int p0;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_eq("rst_csoc_clk", csoc_clk, 0);
        chk_eq("rst_rstn", csoc_rstn, 1);
        chk_eq("rst_se", se, 0);
        chk_eq("rst_tm", tm, 0);
        chk_eq("rst_scan_in", scan_in, 0);
        chk_eq("rst_tx_start", tx_start, 0);
        chk_eq("rst_tx_data", tx_data, 0);
        chk_eq("rst_busy", busy, 0);

        do_status("status_after_reset");

        wait_tx_ready();
        send_byte(8'h02, ts);
        chk_eq("mode_ack_latency", ts, 1);
        tm_m = 1'b1;
        get_tx(b);
        chk_eq("tm_on_ack", b, 8'hAC);
        chk_eq("tm_pin", tm, 1);

        p0 = pulses;
        do_simple(8'h01, 8'hAC, "reset_ack");
        chk_eq("reset_rstn_low_cycles", last_rstn_low, 4 * CLK_DIV);
        chk_eq("reset_pulses", pulses - p0, 2);
        chk_eq("reset_tm_held", tm_bad, 0);
        chk_eq("reset_rstn_back", csoc_rstn, 1);
        do_status("status_tm_set");

        dq = '{8'h05, 8'h0A, 8'h0F};
        do_shift(dq, 1'b0);

        dq = {};
        p0 = pulses;
        do_shift(dq, 1'b0);
        chk_eq("zero_shift_no_edge", pulses - p0, 0);

        do_simple(8'h77, 8'hEE, "nak_0x77");

        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    dq = {};
                    repeat ($urandom_range(0, 5)) dq.push_back(8'($urandom));
                    do_shift(dq, 1'b0);
                end
                1: begin
                    p0 = pulses;
                    do_simple(8'h20, 8'hAC, "capture_ack");
                    chk_eq("capture_pulses", pulses - p0, 1);
                    chk_eq("capture_se", se, 0);
                end
                2: begin
                    v = ($urandom_range(0, 1) == 1) ? 8'h02 : 8'h03;
                    do_simple(v, 8'hAC, "mode_ack");
                    tm_m = (v == 8'h02);
                    chk_eq("mode_tm", tm, tm_m);
                end
                default: begin
                    do begin
                        v = 8'($urandom);
                    end while (v == 8'h01 || v == 8'h02 || v == 8'h03 || v == 8'h10 || v == 8'h20 || v == 8'h30);
                    do_simple(v, 8'hEE, "nak_random");
                end
            endcase
            do_status("status_random");
        end

        dq = '{8'($urandom)};
        do_shift(dq, 1'b1);
        do_status("status_ovf_set");
        do_status("status_ovf_cleared");

        send_byte(8'h10, ts);
        send_byte(8'h05, ts);
        send_byte(8'h00, ts);
        v = 8'($urandom);
        send_byte(v, ts);
        void'(pipe.pop_front());
        pipe.push_back(CHAINS'(v));
        begin
            int t = 0;
            while (csoc_clk !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_eq("midrst_csoc_clk", csoc_clk, 0);
        chk_eq("midrst_se", se, 0);
        chk_eq("midrst_busy", busy, 0);
        chk_eq("midrst_tx_start", tx_start, 0);
        rst = 1'b0;
        tm_m = 1'b0; ovf_m = 1'b0;
        repeat (20) @(negedge clk);
        chk_eq("midrst_no_tx", got_q.size(), 0);
        do_status("status_after_midrst");

        dq = '{8'($urandom), 8'($urandom)};
        do_shift(dq, 1'b0);

`ifdef SCAN_TIMEOUT_EN
        send_byte(8'h10, ts);
        send_byte(8'h01, ts);
        send_byte(8'h00, ts);
        get_tx(b);
        chk_eq("timeout_nak", b, 8'hEE);
        chk_eq("timeout_se", se, 0);
        do_status("status_after_timeout");
`endif

        chk_eq("clk_high_width_errors", bad_hi, 0);
        chk_eq("tx_start_while_busy", tx_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
